ram_wr_arbiter: RTL

- Write-port controller for the replicated 1R1W multi-read RAM (ram_4R1W family).
- Shares the single RAM write port between four write requesters using round-robin arbitration with a valid/ready handshake.
- Sequences a full-memory zero-clear after reset and on request, and signals readiness to the rest of the design.
- Sits between the requester logic and the w_addr/w_din/w_enb inputs of the RAM.

---
 rtl/ram_wr_arbiter_pkg.sv | 15 +
 rtl/ram_wr_arbiter_if.sv | 30 +++
 rtl/ram_wr_arbiter_rr_arbiter4.sv | 28 ++
 rtl/ram_wr_arbiter.sv | 73 +++++++
 4 files changed

// File: rtl/ram_wr_arbiter_pkg.sv
// rtl/ram_wr_arbiter_pkg.sv - shared constants for the RAM write-port arbiter
package ram_wr_arbiter_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam int BLOCLSIZE_DEF = 11;
  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 32;

  function automatic int aw_of(input int blocl_size);
    return blocl_size + 1;
  endfunction

endpackage

// File: rtl/ram_wr_arbiter_if.sv
// rtl/ram_wr_arbiter_if.sv - requester/RAM-side bundle of the write arbiter
interface ram_wr_arbiter_if
  import ram_wr_arbiter_pkg::*;
#(
  parameter int AW   = aw_of(BLOCLSIZE_DEF),
  parameter int DW   = DW_DEF,
  parameter int NREQ = NREQ_DEF
);

  logic                 clr_req;
  logic                 init_done;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_din;
  logic [AW-1:0]        w_addr;
  logic [DW-1:0]        w_din;
  logic                 w_enb;

  modport master (
    output clr_req, req_valid, req_addr, req_din,
    input  init_done, req_ready, w_addr, w_din, w_enb
  );

  modport slave (
    input  clr_req, req_valid, req_addr, req_din,
    output init_done, req_ready, w_addr, w_din, w_enb
  );

endinterface

// File: rtl/ram_wr_arbiter_rr_arbiter4.sv
// rtl/ram_wr_arbiter_rr_arbiter4.sv - combinational 4-way round-robin picker
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic [1:0] cand;
  logic       found;

  // Search ptr, ptr+1, ... with natural 2-bit wrap; first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    cand    = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_wr_arbiter.sv
// rtl/ram_wr_arbiter.sv - shares the RAM write port among four requesters
module ram_wr_arbiter
  import ram_wr_arbiter_pkg::*;
#(
  parameter int BLOCLSIZE = BLOCLSIZE_DEF,
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  localparam int AW       = aw_of(BLOCLSIZE)
) (
  input  logic            clk,
  input  logic            rst,
  ram_wr_arbiter_if.slave bus
);

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [1:0]    rr_ptr;
  logic [3:0]    arb_gnt;
  logic [1:0]    arb_idx;
  logic          grant_en;
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_din;

  rr_arbiter4 u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Grants wait for init_done so nothing is accepted until the sweep is visibly finished.
  assign grant_en      = (state == ST_RUN) && bus.init_done && !bus.clr_req;
  assign bus.req_ready = grant_en ? arb_gnt : '0;
  assign xfer          = |bus.req_ready;
  assign sel_addr      = bus.req_addr[int'(arb_idx)*AW +: AW];
  assign sel_din       = bus.req_din[int'(arb_idx)*DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_CLEAR;
      clr_cnt       <= '0;
      rr_ptr        <= '0;
      bus.w_enb     <= 1'b0;
      bus.w_addr    <= '0;
      bus.w_din     <= '0;
      bus.init_done <= 1'b0;
    end else if (state == ST_CLEAR) begin
      bus.w_enb     <= 1'b1;
      bus.w_addr    <= clr_cnt;
      bus.w_din     <= '0;
      bus.init_done <= 1'b0;
      clr_cnt       <= clr_cnt + AW'(1);
      if (clr_cnt == '1) begin
        state <= ST_RUN;
      end
    end else begin
      bus.init_done <= !bus.clr_req;
      bus.w_enb     <= xfer;
      if (xfer) begin
        bus.w_addr <= sel_addr;
        bus.w_din  <= sel_din;
        rr_ptr     <= arb_idx + 2'd1;
      end
      if (bus.clr_req) begin
        state   <= ST_CLEAR;
        clr_cnt <= '0;
        rr_ptr  <= '0;
      end
    end
  end

endmodule
